// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues data-memory accesses for loads/stores,
// waits for the memory ack (bounded), and presents the write-back slot.
module mem_wb_stage #(
    parameter int ACK_TIMEOUT = 15,
    parameter int ADDR_W      = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic [31:0]       ALUResult_i,
    input  logic [31:0]       rdata2_i,
    input  logic [4:0]        rd_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic [31:0]       dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic              RegWrite_o,
    output logic [4:0]        rd_o,
    output logic [31:0]       wdata_o,
    output logic              err_o
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    logic             memop, illegal, legal_memop;

    // Captured instruction fields kept for the write-back after the ack.
    logic [4:0]       cap_rd;
    logic             cap_rw;
    logic             cap_m2r;
    logic [31:0]      cap_alu;

    assign memop       = valid_i & (MemRead_i | MemWrite_i);
    assign illegal     = (ALUResult_i[1:0] != 2'b00) | (MemRead_i & MemWrite_i);
    assign legal_memop = memop & ~illegal;
    // Timeout is raised once ACK_TIMEOUT ack-less cycles have elapsed; an ack
    // arriving in that same cycle still completes the access normally.
    assign timeout     = (wait_cnt == CNT_W'(ACK_TIMEOUT));
    assign dmem_req_o  = (state == ACCESS);

    // Next-state and stall decode.
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        case (state)
            IDLE: begin
                if (legal_memop) begin
                    stall_o   = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                stall_o = ~dmem_ack_i & ~timeout;
                if (dmem_ack_i | timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Ack-wait counter: zero while idle, counts ack-less ACCESS cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 wait_cnt <= '0;
        else if (state == IDLE)                     wait_cnt <= '0;
        else if (!dmem_ack_i && !timeout)           wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // Capture the memory request and write-back context on ACCESS entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            cap_rd       <= '0;
            cap_rw       <= 1'b0;
            cap_m2r      <= 1'b0;
            cap_alu      <= '0;
        end else if (state == IDLE && legal_memop) begin
            dmem_we_o    <= MemWrite_i;
            dmem_addr_o  <= ALUResult_i[ADDR_W+1:2];
            dmem_wdata_o <= rdata2_i;
            cap_rd       <= rd_i;
            cap_rw       <= RegWrite_i;
            cap_m2r      <= MemtoReg_i;
            cap_alu      <= ALUResult_i;
        end
    end

    // Write-back slot and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            RegWrite_o <= 1'b0;
            rd_o       <= '0;
            wdata_o    <= '0;
            err_o      <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!valid_i) begin
                        valid_o    <= 1'b0;
                        RegWrite_o <= 1'b0;
                    end else if (memop && illegal) begin
                        valid_o    <= 1'b1;
                        RegWrite_o <= 1'b0;
                        err_o      <= 1'b1;
                    end else if (memop) begin
                        valid_o    <= 1'b0;
                        RegWrite_o <= 1'b0;
                    end else begin
                        valid_o    <= 1'b1;
                        RegWrite_o <= RegWrite_i & (rd_i != 5'd0);
                        rd_o       <= rd_i;
                        wdata_o    <= ALUResult_i;
                    end
                end
                ACCESS: begin
                    if (dmem_ack_i) begin
                        valid_o    <= 1'b1;
                        RegWrite_o <= cap_rw & ~dmem_we_o & (cap_rd != 5'd0);
                        rd_o       <= cap_rd;
                        wdata_o    <= cap_m2r ? dmem_rdata_i : cap_alu;
                    end else if (timeout) begin
                        valid_o    <= 1'b1;
                        RegWrite_o <= 1'b0;
                        err_o      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_wb_stage;
    localparam int T  = 15;
    localparam int AW = 14;

    logic clk = 1'b0, rst_n = 1'b0;
    logic valid_i = 0, RegWrite_i = 0, MemRead_i = 0, MemWrite_i = 0, MemtoReg_i = 0;
    logic [31:0] ALUResult_i = 0, rdata2_i = 0, dmem_rdata_i = 0;
    logic [4:0] rd_i = 0;
    logic dmem_ack_i = 0;
    logic dmem_req_o, dmem_we_o, stall_o, valid_o, RegWrite_o, err_o;
    logic [AW-1:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o, wdata_o;
    logic [4:0] rd_o;

    mem_wb_stage #(.ACK_TIMEOUT(T), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i),
        .ALUResult_i(ALUResult_i), .rdata2_i(rdata2_i), .rd_i(rd_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .stall_o(stall_o), .valid_o(valid_o), .RegWrite_o(RegWrite_o), .rd_o(rd_o),
        .wdata_o(wdata_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: one pending memory transaction plus the expected write-back slot.
    logic        m_busy;
    int          m_wait;
    logic [4:0]  c_rd;
    logic        c_rw, c_m2r, c_we;
    logic [31:0] c_alu, c_wd;
    logic [AW-1:0] c_addr;
    logic        e_valid, e_rw, e_err, e_dchk;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        last_stall;
    int          stall_cnt, req_cnt, err_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_wait = 0; e_valid = 0; e_rw = 0; e_err = 0;
        e_rd = 0; e_wd = 0; e_dchk = 1; last_stall = 0;
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step(input logic v, rw, mr, mw, m2r, input logic [31:0] alu, d2,
                        input logic [4:0] rd, input logic ack, input logic [31:0] rdat);
        logic memop, bad, x_stall;
        @(negedge clk);
        valid_i = v; RegWrite_i = rw; MemRead_i = mr; MemWrite_i = mw; MemtoReg_i = m2r;
        ALUResult_i = alu; rdata2_i = d2; rd_i = rd; dmem_ack_i = ack; dmem_rdata_i = rdat;
        #1;
        memop   = v & (mr | mw);
        bad     = (alu[1:0] != 2'b00) || (mr && mw);
        x_stall = m_busy ? (!ack && m_wait != T) : (memop && !bad);
        chk("stall", stall_o, x_stall);
        chk("req", dmem_req_o, m_busy);
        if (m_busy) begin
            chk("we", dmem_we_o, c_we);
            chk("addr", dmem_addr_o, c_addr);
            chk("mwdata", dmem_wdata_o, c_wd);
        end
        chk("valid", valid_o, e_valid);
        chk("regwrite", RegWrite_o, e_rw);
        chk("err", err_o, e_err);
        if (e_dchk) begin
            chk("rd", rd_o, e_rd);
            chk("wdata", wdata_o, e_wd);
        end
        last_stall = x_stall;
        stall_cnt += int'(stall_o);
        req_cnt   += int'(dmem_req_o);
        @(posedge clk);
        e_err = 0;
        if (m_busy) begin
            if (ack) begin
                e_valid = 1; e_rw = c_rw && !c_we && c_rd != 0;
                e_rd = c_rd; e_wd = c_m2r ? rdat : c_alu; e_dchk = 1; m_busy = 0;
            end else if (m_wait == T) begin
                e_valid = 1; e_rw = 0; e_err = 1; e_dchk = 0; m_busy = 0;
            end else m_wait++;
        end else if (!v) begin
            e_valid = 0; e_rw = 0;
        end else if (memop && bad) begin
            e_valid = 1; e_rw = 0; e_err = 1; e_dchk = 0;
        end else if (memop) begin
            m_busy = 1; m_wait = 0; c_rd = rd; c_rw = rw; c_m2r = m2r; c_we = mw;
            c_alu = alu; c_wd = d2; c_addr = alu[AW+1:2];
            e_valid = 0; e_rw = 0; e_dchk = 0;
        end else begin
            e_valid = 1; e_rw = rw && rd != 0; e_rd = rd; e_wd = alu; e_dchk = 1;
        end
        #1;
        err_cnt += int'(err_o);
    endtask

    task automatic idle(input logic ack);
        step(0, 0, 0, 0, 0, 0, 0, 0, ack, 32'h0);
    endtask

    logic        r_v, r_rw, r_mr, r_mw, r_m2r;
    logic [31:0] r_alu, r_d2;
    logic [4:0]  r_rd;

    initial begin
        model_reset();
        stall_cnt = 0; req_cnt = 0; err_cnt = 0;
        #3;
        chk("rst_req", dmem_req_o, 0);    chk("rst_valid", valid_o, 0);
        chk("rst_rw", RegWrite_o, 0);     chk("rst_rd", rd_o, 0);
        chk("rst_wdata", wdata_o, 0);     chk("rst_err", err_o, 0);
        chk("rst_addr", dmem_addr_o, 0);  chk("rst_we", dmem_we_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle(1);  // stray ack while idle must be ignored

        // ALU op: one-cycle latency, no stall
        stall_cnt = 0;
        step(1, 1, 0, 0, 0, 32'h1234, 0, 5, 0, 0);
        chk("alu_valid", valid_o, 1); chk("alu_rw", RegWrite_o, 1);
        chk("alu_rd", rd_o, 5);       chk("alu_wdata", wdata_o, 32'h1234);
        chk("alu_stall", stall_cnt, 0);

        // Load with three wait cycles
        stall_cnt = 0;
        step(1, 1, 1, 0, 1, 32'h40, 0, 7, 0, 0);
        chk("ld_req", dmem_req_o, 1); chk("ld_addr", dmem_addr_o, 14'h10);
        chk("ld_we", dmem_we_o, 0);
        repeat (3) step(1, 1, 1, 0, 1, 32'h40, 0, 7, 0, 32'h1111);
        step(1, 1, 1, 0, 1, 32'h40, 0, 7, 1, 32'hDEADBEEF);
        chk("ld_stall_cycles", stall_cnt, 4);
        chk("ld_valid", valid_o, 1);  chk("ld_rw", RegWrite_o, 1);
        chk("ld_rd", rd_o, 7);        chk("ld_wdata", wdata_o, 32'hDEADBEEF);
        chk("ld_req_drop", dmem_req_o, 0);

        // Store: no register write
        step(1, 1, 0, 1, 0, 32'h8, 32'hA5, 3, 0, 0);
        chk("st_we", dmem_we_o, 1); chk("st_addr", dmem_addr_o, 2);
        chk("st_wdata", dmem_wdata_o, 32'hA5);
        step(1, 1, 0, 1, 0, 32'h8, 32'hA5, 3, 1, 32'h77);
        chk("st_valid", valid_o, 1); chk("st_rw", RegWrite_o, 0);

        // Misaligned load: no request, single err pulse
        req_cnt = 0; err_cnt = 0; stall_cnt = 0;
        step(1, 1, 1, 0, 1, 32'h42, 0, 9, 0, 0);
        chk("mis_err", err_o, 1); chk("mis_valid", valid_o, 1); chk("mis_rw", RegWrite_o, 0);
        idle(0);
        chk("mis_req_cnt", req_cnt, 0); chk("mis_err_cnt", err_cnt, 1);
        chk("mis_stall", stall_cnt, 0);

        // Timeout: request held T ack-less cycles plus the timeout cycle
        req_cnt = 0; err_cnt = 0;
        step(1, 1, 1, 0, 1, 32'h100, 0, 4, 0, 0);
        for (int i = 0; i < 40 && dmem_req_o; i++) step(1, 1, 1, 0, 1, 32'h100, 0, 4, 0, 0);
        chk("to_req_cycles", req_cnt, T + 1);
        chk("to_err", err_o, 1); chk("to_req", dmem_req_o, 0);
        chk("to_rw", RegWrite_o, 0); chk("to_valid", valid_o, 1);
        idle(0);
        chk("to_err_cnt", err_cnt, 1);

        // Reset in the second ACCESS cycle
        step(1, 1, 1, 0, 1, 32'h20, 0, 6, 0, 0);
        step(1, 1, 1, 0, 1, 32'h20, 0, 6, 0, 0);
        @(negedge clk);
        dmem_ack_i = 0; valid_i = 0; MemRead_i = 0; MemtoReg_i = 0; RegWrite_i = 0;
        #1;
        chk("rs_req_before", dmem_req_o, 1);
        rst_n = 0;
        #1;
        chk("rs_req_async", dmem_req_o, 0); chk("rs_valid", valid_o, 0);
        chk("rs_err", err_o, 0);            chk("rs_stall", stall_o, 0);
        model_reset();
        @(posedge clk); #1;
        chk("rs_err_edge", err_o, 0); chk("rs_valid_edge", valid_o, 0);
        @(negedge clk); rst_n = 1;
        step(1, 1, 0, 0, 0, 32'hCAFE, 0, 12, 0, 0);
        chk("rs_alu_rw", RegWrite_o, 1); chk("rs_alu_wdata", wdata_o, 32'hCAFE);

        // rd = 0 never writes
        step(1, 1, 0, 0, 0, 32'h55, 0, 0, 0, 0);
        chk("rd0_rw", RegWrite_o, 0);

        // Randomized traffic; upstream holds the instruction while stalled
        last_stall = 0;
        r_v = 0; r_rw = 0; r_mr = 0; r_mw = 0; r_m2r = 0; r_alu = 0; r_d2 = 0; r_rd = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                r_v   = ($urandom_range(0, 9) < 8);
                r_rw  = $urandom_range(0, 1);
                r_rd  = 5'($urandom_range(0, 31));
                r_d2  = $urandom;
                r_alu = $urandom;
                r_mr  = 0; r_mw = 0; r_m2r = 0;
                if ($urandom_range(0, 9) < 4) begin
                    r_mr = $urandom_range(0, 1); r_mw = !r_mr;
                    if ($urandom_range(0, 19) == 0) begin r_mr = 1; r_mw = 1; end
                    r_m2r = r_mr;
                    if ($urandom_range(0, 6) != 0) r_alu[1:0] = 2'b00;
                end
            end
            step(r_v, r_rw, r_mr, r_mw, r_m2r, r_alu, r_d2, r_rd,
                 ($urandom_range(0, 9) < 3), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
